// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/redirect control, mul/div wait FSM, event counters.
// Optional feature: define HAZARD_FORWARD_EN for EX-stage forwarding (otherwise RAW hazards stall).
module hazard_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemReadE,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteW,
  input  logic                 PCSrcE,
  input  logic                 MdStartE,
  input  logic                 MdDone,
  input  logic                 CntClr,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 EnDE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MdError,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(MD_TIMEOUT - 1);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          lu_hit;
  logic          dep_hit;
  logic          stall_hit;
  logic          md_hold;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign lu_hit = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HAZARD_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = RegWriteE;
  assign dep_hit    = 1'b0;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegWriteW};
  assign ForwardAE  = 2'b00;
  assign ForwardBE  = 2'b00;
  // Without forwarding any in-flight producer of a Decode source must stall.
  assign dep_hit = (RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                   (RegWriteM && (RdM != 5'd0) && ((RdM == Rs1D) || (RdM == Rs2D)));
`endif

  assign stall_hit = lu_hit || dep_hit;
  assign md_hold   = !MdDone && ((state == MD_WAIT) || MdStartE);

  // The mul/div hold dominates; in RUN a redirect beats a data-hazard stall.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    EnDE   = 1'b1;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (md_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      EnDE   = 1'b0;
    end else if (state == RUN) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (stall_hit) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      tcnt    <= '0;
      MdError <= 1'b0;
    end else begin
      MdError <= 1'b0;
      case (state)
        RUN: begin
          if (MdStartE && !MdDone) begin
            state <= MD_WAIT;
            tcnt  <= '0;
          end
        end
        MD_WAIT: begin
          if (MdDone) begin
            state <= RUN;
          end else if (tcnt == T_MAX) begin
            state   <= RUN;
            MdError <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD) StallCnt <= sat_inc(StallCnt);
      if (FlushE) FlushCnt <= sat_inc(FlushCnt);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (small counters to reach saturation quickly).
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk, rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, MemReadE, RegWriteM, RegWriteW, PCSrcE, MdStartE, MdDone, CntClr;
  logic StallF, StallD, EnDE, FlushD, FlushE, MdError;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  int cnt;
  int bad;

  hazard_unit #(.MD_TIMEOUT(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDone(MdDone), .CntClr(CntClr),
    .StallF(StallF), .StallD(StallD), .EnDE(EnDE), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdError(MdError),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Advance one clock; s/f are the stall/flush levels the bench expects this cycle.
  task automatic tick(input bit s, input bit f);
    if (CntClr) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      exp_sc = sat(exp_sc + int'(s));
      exp_fc = sat(exp_fc + int'(f));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; MemReadE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; MdStartE = 0; MdDone = 0; CntClr = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_stallcnt", 32'(StallCnt), 0);
    chk("rst_flushcnt", 32'(FlushCnt), 0);
    chk("rst_mderror", 32'(MdError), 0);
    chk("rst_ende", 32'(EnDE), 1);
    chk("rst_stallf", 32'(StallF), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Forwarding priority and x0 handling
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    #1;
    chk("fwdA_mem", 32'(ForwardAE), FWD ? 2 : 0);
    chk("fwdB_mem", 32'(ForwardBE), FWD ? 2 : 0);
    RdM = 0;
    #1;
    chk("fwdA_wb", 32'(ForwardAE), FWD ? 1 : 0);
    chk("fwdB_wb", 32'(ForwardBE), FWD ? 1 : 0);
    RdW = 0; Rs1E = 0;
    #1;
    chk("fwdA_x0", 32'(ForwardAE), 0);
    chk("fwd_nostall", 32'(StallD), 0);
    tick(0, 0);
    idle_inputs();

    // Load-use on Rs2D
    MemReadE = 1; RdE = 7; Rs2D = 7;
    #1;
    chk("lu_stallf", 32'(StallF), 1);
    chk("lu_stalld", 32'(StallD), 1);
    chk("lu_flushe", 32'(FlushE), 1);
    chk("lu_flushd", 32'(FlushD), 0);
    chk("lu_ende", 32'(EnDE), 1);
    tick(1, 1);
    chk("lu_stallcnt", 32'(StallCnt), 32'(exp_sc));
    chk("lu_flushcnt", 32'(FlushCnt), 32'(exp_fc));
    MemReadE = 0;
    #1;
    chk("lu_release", 32'(StallD), 0);

    // Load to x0 never stalls
    MemReadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    chk("lu_x0", 32'(StallD), 0);
    tick(0, 0);

    // Redirect overrides load-use
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1;
    chk("redir_flushd", 32'(FlushD), 1);
    chk("redir_flushe", 32'(FlushE), 1);
    chk("redir_stalld", 32'(StallD), 0);
    chk("redir_stallf", 32'(StallF), 0);
    tick(0, 1);
    chk("redir_flushcnt", 32'(FlushCnt), 32'(exp_fc));
    chk("redir_stallcnt", 32'(StallCnt), 32'(exp_sc));
    idle_inputs();

    // ALU RAW dependency: stalls only without forwarding
    RdE = 3; RegWriteE = 1; Rs1D = 3;
    #1;
    chk("raw_stalld", 32'(StallD), FWD ? 0 : 1);
    chk("raw_fwdA", 32'(ForwardAE), 0);
    tick(!FWD, !FWD);
    chk("raw_stallcnt", 32'(StallCnt), 32'(exp_sc));
    idle_inputs();

    // Mul/div finishing after 10 stalled cycles; PCSrcE ignored throughout
    MdStartE = 1; PCSrcE = 1;
    #1;
    chk("md_start_ende", 32'(EnDE), 0);
    chk("md_start_flushd", 32'(FlushD), 0);
    cnt = (EnDE == 1'b0) ? 1 : 0;
    tick(1, 0);
    MdStartE = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (EnDE == 1'b0) cnt++;
      tick(1, 0);
    end
    MdDone = 1;
    #1;
    chk("md_done_ende", 32'(EnDE), 1);
    chk("md_done_stalld", 32'(StallD), 0);
    chk("md_done_flushd", 32'(FlushD), 0);
    chk("md_hold_cycles", 32'(cnt), 10);
    tick(0, 0);
    MdDone = 0;
    #1;
    chk("md_back_run", 32'(FlushD), 1);
    chk("md_no_error", 32'(MdError), 0);
    chk("md_stallcnt", 32'(StallCnt), 32'(exp_sc));
    PCSrcE = 0;

    // Saturation then clear with priority over a live increment
    MemReadE = 1; RdE = 9; Rs1D = 9;
    for (int i = 0; i < 6; i++) tick(1, 1);
    chk("sat_stallcnt", 32'(StallCnt), CMAX);
    chk("sat_flushcnt", 32'(FlushCnt), 32'(exp_fc));
    CntClr = 1;
    tick(1, 1);
    chk("clr_stallcnt", 32'(StallCnt), 0);
    chk("clr_flushcnt", 32'(FlushCnt), 0);
    idle_inputs();

    // Mul/div timeout: 64 MD_WAIT cycles then a single MdError pulse
    MdStartE = 1;
    #1;
    tick(1, 0);
    MdStartE = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (StallD !== 1'b1 || MdError !== 1'b0) bad++;
      tick(1, 0);
    end
    chk("to_hold", 32'(bad), 0);
    chk("to_error", 32'(MdError), 1);
    chk("to_run_ende", 32'(EnDE), 1);
    chk("to_stallcnt", 32'(StallCnt), 32'(exp_sc));
    tick(0, 0);
    chk("to_pulse_end", 32'(MdError), 0);

    // Asynchronous reset in the middle of MD_WAIT
    MdStartE = 1;
    #1;
    tick(1, 0);
    MdStartE = 0;
    tick(1, 0);
    #2;
    rst = 1'b1;
    exp_sc = 0;
    exp_fc = 0;
    #1;
    chk("rstmd_ende", 32'(EnDE), 1);
    chk("rstmd_stalld", 32'(StallD), 0);
    chk("rstmd_stallcnt", 32'(StallCnt), 0);
    chk("rstmd_flushcnt", 32'(FlushCnt), 0);
    chk("rstmd_mderror", 32'(MdError), 0);
    rst = 1'b0;
    tick(0, 0);
    chk("rstmd_run", 32'(EnDE), 1);
    chk("rstmd_noerr", 32'(MdError), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
